// File: rtl/mul_iterative_radix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and helpers for the iterative RV32M/RV64M
//                multiplier (operation codes, FSM states, signedness).
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Encoding matches funct3[1:0] of the RV M-extension multiply group.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MULH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iterative_radix_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iterative_radix_if
//  Description : Request/response bundle between the execute stage and the
//                iterative multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_iterative_radix_if
  import mul_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            start_i;
  mul_op_e         op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Pipeline side: issues requests and consumes the result.
  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  ready_o, busy_o, done_o, result_o
  );

  // Multiplier side.
  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output ready_o, busy_o, done_o, result_o
  );

endinterface
`default_nettype wire

// File: rtl/mul_iterative_radix_pp_step.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pp_step
//  Description : Combinational partial product for one iteration: the
//                multiplicand times a BITS_PER_CYCLE-wide multiplier digit,
//                placed at its bit position in the 2*XLEN accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_pp_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int SH_W           = $clog2(2*XLEN)
) (
  input  wire logic [XLEN-1:0]           mcand_i,
  input  wire logic [BITS_PER_CYCLE-1:0] bits_i,
  input  wire logic [SH_W-1:0]           shamt_i,
  output      logic [2*XLEN-1:0]         pp_o
);

  localparam int PW = 2*XLEN;

  logic [PW-1:0] w_ext_mcand;
  logic [PW-1:0] w_ext_bits;
  logic [PW-1:0] w_raw;

  // Operands are magnitudes, so zero extension is always correct here.
  assign w_ext_mcand = {{XLEN{1'b0}}, mcand_i};
  assign w_ext_bits  = {{(PW-BITS_PER_CYCLE){1'b0}}, bits_i};
  assign w_raw       = w_ext_mcand * w_ext_bits;
  assign pp_o        = w_raw << shamt_i;

endmodule
`default_nettype wire

// File: rtl/mul_iterative_radix.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iterative_radix
//  Description : Fixed-latency iterative multiplier (MUL/MULH/MULHSU/MULHU).
//                Works on operand magnitudes, retiring BITS_PER_CYCLE
//                multiplier bits per cycle, then applies the sign in one
//                fix-up cycle. Latency is XLEN/BITS_PER_CYCLE + 2 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iterative_radix
  import mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input wire logic             clk,
  input wire logic             rst,
  mul_iterative_radix_if.slave bus
);

  localparam int K     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K);
  localparam int SH_W  = $clog2(2*XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  mul_state_e         state_q,  state_d;
  mul_op_e            op_q,     op_d;
  logic [XLEN-1:0]    mcand_q,  mcand_d;
  logic [XLEN-1:0]    mplier_q, mplier_d;
  logic               neg_q,    neg_d;
  logic [2*XLEN-1:0]  acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [XLEN-1:0]    result_q, result_d;

  logic               w_ready;
  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [SH_W-1:0]    w_shamt;
  logic [2*XLEN-1:0]  w_pp;
  logic [2*XLEN-1:0]  w_prod;

  assign w_ready  = (state_q == IDLE) || (state_q == DONE);
  assign w_accept = bus.start_i && w_ready && !bus.flush_i;
  assign w_a_neg  = op_a_signed(bus.op_i) & bus.a_i[XLEN-1];
  assign w_b_neg  = op_b_signed(bus.op_i) & bus.b_i[XLEN-1];
  assign w_shamt  = SH_W'(cnt_q) * SH_W'(BITS_PER_CYCLE);
  assign w_prod   = neg_q ? -acc_q : acc_q;

  mul_pp_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SH_W           (SH_W)
  ) u_pp_step (
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BITS_PER_CYCLE-1:0]),
    .shamt_i (w_shamt),
    .pp_o    (w_pp)
  );

  // State and datapath registers; reset returns everything to zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update; flush wins over everything, including
  // a start in the same cycle, and never touches the held result.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (w_accept) begin
            state_d  = CALC;
            op_d     = bus.op_i;
            // -(2^(XLEN-1)) wraps to itself, which is the correct magnitude.
            mcand_d  = w_a_neg ? -bus.a_i : bus.a_i;
            mplier_d = w_b_neg ? -bus.b_i : bus.b_i;
            neg_d    = w_a_neg ^ w_b_neg;
            acc_d    = '0;
            cnt_d    = '0;
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        CALC: begin
          acc_d    = acc_q + w_pp;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end
        end
        FIX: begin
          result_d = (op_q == MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
          state_d  = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.busy_o   = (state_q == CALC) || (state_q == FIX);
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;

endmodule
`default_nettype wire

// File: doc/mul_iterative_radix.md
Name: mul_iterative_radix

Overview:
- Parametrised, fixed-latency iterative multiplier for the RV32M/RV64M execute stage.
- Implements MUL, MULH, MULHSU and MULHU with correct signed/unsigned semantics.
- Retires BITS_PER_CYCLE multiplier bits per cycle, and exposes a ready/start/done handshake plus a pipeline flush.
- The pipeline stalls on busy_o and captures result_o on done_o.

Parameters:
XLEN, 32, operand and result width (32 or 64)
BITS_PER_CYCLE, 2, multiplier bits consumed per CALC cycle; must divide XLEN (1, 2, 4 or 8)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  request; accepted on a rising edge where start_i && ready_o && !flush_i
op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; sampled at accept
a_i  in  XLEN  rs1 operand; sampled at accept
b_i  in  XLEN  rs2 operand; sampled at accept
flush_i  in  1  abort the in-flight operation (branch mispredict or trap)
ready_o  out  1  can accept a request this cycle
busy_o  out  1  operation in flight (CALC or FIX)
done_o  out  1  one-cycle pulse; result_o valid
result_o  out  XLEN  selected half of the product; held until the next accept or reset

Behaviour:
- Reset (asynchronous): state=IDLE; ready_o=1; busy_o=0; done_o=0; result_o=0; all internal registers 0.
- States: IDLE, CALC, FIX, DONE. Let K = XLEN/BITS_PER_CYCLE.
- IDLE: ready_o=1. On accept, go to CALC and:
  - latch op;
  - latch magnitudes |a| and |b|;
  - latch neg = (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]);
  - a_signed = op is MULH or MULHSU; b_signed = op is MULH;
  - clear the 2*XLEN accumulator and the counter.
- Magnitude of the most negative value equals 2^(XLEN-1). This is representable as unsigned XLEN, so no overflow special case exists.
- CALC, each cycle:
  - acc += (mcand * mplier[BITS_PER_CYCLE-1:0]) << (counter*BITS_PER_CYCLE);
  - mplier >>= BITS_PER_CYCLE;
  - counter++;
  - after exactly K cycles, go to FIX;
  - no early termination: latency is fixed and independent of operand values.
- FIX:
  - product = neg ? -acc : acc (2*XLEN two's complement);
  - result_o <= product[XLEN-1:0] for MUL, otherwise product[2XLEN-1:XLEN];
  - go to DONE.
- DONE:
  - done_o=1 for exactly this cycle; ready_o=1;
  - accept -> CALC (back-to-back, no idle bubble); else -> IDLE.
- Timing: with start accepted in cycle 0, CALC occupies cycles 1..K, FIX cycle K+1, done_o is high in cycle K+2. Default K=16, so done_o is high in cycle 18.
- busy_o = state is CALC or FIX. ready_o = state is IDLE or DONE.
- start_i while busy_o=1: ignored, with no effect on state or operands.
- flush_i:
  - in any state, next edge -> IDLE;
  - done_o stays 0; result_o keeps its old value;
  - flush_i has priority over a simultaneous start_i (no accept);
  - flush_i in DONE does not cancel the done_o already high that cycle.
- Reset mid-operation: immediate return to reset values; no done_o.
- op_i, a_i and b_i may change freely after accept.

Decomposition:
- Package mul_pkg:
  - typedef enum logic [1:0] mul_op_e {MUL, MULH, MULHSU, MULHU};
  - typedef enum mul_state_e {IDLE, CALC, FIX, DONE};
  - function op_a_signed(op) and function op_b_signed(op).
- Sub-module mul_pp_step (combinational): given mcand, BITS_PER_CYCLE multiplier bits and shift amount, returns the 2*XLEN partial product. This keeps the top-level focused on the FSM and handshake.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; done_o high exactly in cycle 18 after accept; busy_o high in cycles 1..17.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Back-to-back: new start in the DONE cycle of MULHU 0xFFFFFFFF×0xFFFFFFFF (result 0xFFFFFFFE) -> second op accepted with no bubble, its done_o 18 cycles later; a start pulsed in CALC is ignored.
- Flush in CALC cycle 5 together with start_i=1 -> IDLE next cycle, no done_o, result_o unchanged, ready_o=1.
- Async rst asserted mid-CALC between clock edges -> outputs at reset values immediately; the next op after release completes correctly.
- Parameter sweep XLEN=32 and 64, BITS_PER_CYCLE=1, 2, 4, 8: 10k random operands and ops vs a reference model. Latency is K+2 in every configuration.
